// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch and decode stages: opcode map,
// instruction width and the fetch controller state type.
package isa_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_ADD      = 4'h0;
    localparam logic [3:0] OP_SUB      = 4'h1;
    localparam logic [3:0] OP_AND      = 4'h2;
    localparam logic [3:0] OP_OR       = 4'h3;
    localparam logic [3:0] OP_LOAD     = 4'h8;
    localparam logic [3:0] OP_STORE    = 4'h9;
    localparam logic [3:0] OP_BRANCH   = 4'hC;
    localparam logic [3:0] OP_JUMP     = 4'hD;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        RUN,
        STALLED,
        HALTED
    } fetch_state_t;

    function automatic logic is_halt_op(input logic [3:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side
// instruction, stall, redirect and halt signals.
interface fetch_stage_if #(
    parameter int N      = isa_pkg::INSTR_W,
    parameter int ADDR_W = 16
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [N-1:0]      imem_data;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [N-1:0]      instruction;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;

    modport master (
        output imem_en, imem_addr, instruction, instr_pc, instr_valid, halted,
        input  imem_data, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, instruction, instr_pc, instr_valid, halted,
        output imem_data, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry hold register that parks the presented instruction while
// decode is stalled. Clear wins over load.
module fetch_hold_buf
    import isa_pkg::*;
#(
    parameter int N      = INSTR_W,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [N-1:0]      d_instr,
    input  logic [ADDR_W-1:0] d_pc,
    output logic              valid,
    output logic [N-1:0]      instr,
    output logic [ADDR_W-1:0] pc
);

    logic              hold_valid_q, hold_valid_d;
    logic [N-1:0]      hold_q, hold_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        hold_pc_d    = hold_pc_q;
        if (clear) begin
            hold_valid_d = 1'b0;
        end else if (load) begin
            hold_valid_d = 1'b1;
            hold_d       = d_instr;
            hold_pc_d    = d_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            hold_pc_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign valid = hold_valid_q;
    assign instr = hold_q;
    assign pc    = hold_pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// presents instructions to decode. FETCH_PERF_COUNTERS_EN adds perf counters.
module fetch_stage
    import isa_pkg::*;
#(
    parameter int                N        = INSTR_W,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles,
`endif
    fetch_stage_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              f_valid_q, f_valid_d;
    logic [ADDR_W-1:0] f_pc_q, f_pc_d;

    logic              hold_valid, hold_load, hold_clear;
    logic [N-1:0]      hold_instr;
    logic [ADDR_W-1:0] hold_pc;

    logic [N-1:0]      sel_instr;
    logic [ADDR_W-1:0] sel_pc;
    logic              instr_valid, consume, halt_consumed;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;

    fetch_hold_buf #(.N(N), .ADDR_W(ADDR_W)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .clear   (hold_clear),
        .d_instr (bus.imem_data),
        .d_pc    (f_pc_q),
        .valid   (hold_valid),
        .instr   (hold_instr),
        .pc      (hold_pc)
    );

    always_comb begin
        sel_instr     = hold_valid ? hold_instr : bus.imem_data;
        sel_pc        = hold_valid ? hold_pc : f_pc_q;
        instr_valid   = (hold_valid | f_valid_q) & ~bus.redirect_valid & (state_q != HALTED);
        consume       = instr_valid & ~bus.stall;
        halt_consumed = consume & is_halt_op(sel_instr[N-1 -: 4]);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f_valid_d  = f_valid_q;
        f_pc_d     = f_pc_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        issue      = 1'b0;
        issue_addr = pc_q;

        if (bus.redirect_valid) begin
            // Redirect beats stall and halt; the in-flight word is squashed.
            issue      = 1'b1;
            issue_addr = bus.redirect_pc;
            hold_clear = 1'b1;
            f_valid_d  = 1'b1;
            f_pc_d     = bus.redirect_pc;
            pc_d       = bus.redirect_pc + ADDR_W'(1);
            state_d    = RUN;
        end else begin
            case (state_q)
                RUN, STALLED: begin
                    // Releasing a stall consumes the hold and issues the next PC together.
                    issue     = ~bus.stall;
                    f_valid_d = issue;
                    if (issue) begin
                        pc_d   = pc_q + ADDR_W'(1);
                        f_pc_d = pc_q;
                    end
                    if (halt_consumed) begin
                        f_valid_d  = 1'b0;
                        hold_clear = 1'b1;
                        state_d    = HALTED;
                    end else if (bus.stall && instr_valid) begin
                        hold_load = ~hold_valid;
                        state_d   = STALLED;
                    end else begin
                        hold_clear = consume;
                        state_d    = RUN;
                    end
                end
                HALTED: begin
                    f_valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
            f_pc_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_valid_q <= f_valid_d;
            f_pc_q    <= f_pc_d;
        end
    end

    assign bus.imem_en     = issue & ~rst;
    assign bus.imem_addr   = issue_addr;
    assign bus.instruction = (hold_valid | f_valid_q) ? sel_instr : '0;
    assign bus.instr_pc    = sel_pc;
    assign bus.instr_valid = instr_valid;
    assign bus.halted      = (state_q == HALTED);

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(consume);
        perf_stall_d   = perf_stall_q + 32'(bus.stall & instr_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
